// File: rtl/video_timing_gen.sv
// Video raster timing generator: pixel clock-enable divider, h/v counters,
// zero-skew registered sync/blank/de outputs and a line-match interrupt.
module video_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int IRQ_LINE = 480,
  parameter int HW       = 10,
  parameter int VW       = 10
) (
  input  logic          clk,
  input  logic          nRESET,
  input  logic          enable,
  input  logic          irq_ack_n,
  output logic          ce_pix,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          de,
  output logic          line_start,
  output logic          frame_start,
  output logic          irq_n
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_BLANK  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_BLANK  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          HS_ACT   = 1'(HS_POL);
  localparam logic          VS_ACT   = 1'(VS_POL);
  localparam logic          IRQ_EN   = (IRQ_LINE >= 0) && (IRQ_LINE < V_TOTAL);
  localparam logic [VW-1:0] IRQ_V    = IRQ_EN ? VW'(IRQ_LINE) : '0;

  if (CLK_DIV < 1) begin : g_chk_div
    $error("CLK_DIV must be at least 1");
  end
  if (H_TOTAL - 1 >= (1 << HW)) begin : g_chk_hw
    $error("H_TOTAL-1 does not fit in HW bits");
  end
  if (V_TOTAL - 1 >= (1 << VW)) begin : g_chk_vw
    $error("V_TOTAL-1 does not fit in VW bits");
  end

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_next;
  logic [HW-1:0] h_next;
  logic [VW-1:0] v_next;
  logic          h_last;
  logic          v_last;
  logic          irq_set;

  // nRESET gating keeps ce_pix low during reset even when CLK_DIV=1
  assign ce_pix      = enable & nRESET & (div_cnt == DIV_LAST);
  assign h_last      = (hcount == H_LAST);
  assign v_last      = (vcount == V_LAST);
  assign line_start  = ce_pix & h_last;
  assign frame_start = line_start & v_last;
  assign irq_set     = line_start & IRQ_EN & (v_next == IRQ_V);

  always_comb begin
    div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    h_next   = hcount;
    v_next   = vcount;
    if (ce_pix) begin
      if (h_last) begin
        h_next = '0;
        v_next = v_last ? '0 : vcount + 1'b1;
      end else begin
        h_next = hcount + 1'b1;
      end
    end
  end

  // Decoded outputs load from the next counter values so they never lag the counters.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      div_cnt <= '0;
      hcount  <= '0;
      vcount  <= '0;
      hsync   <= ~HS_ACT;
      vsync   <= ~VS_ACT;
      hblank  <= 1'b0;
      vblank  <= 1'b0;
      de      <= 1'b1;
      irq_n   <= 1'b1;
    end else begin
      if (!irq_ack_n) begin
        irq_n <= 1'b1;
      end else if (irq_set) begin
        irq_n <= 1'b0;
      end
      if (enable) begin
        div_cnt <= div_next;
        hcount  <= h_next;
        vcount  <= v_next;
        hsync   <= ((h_next >= HS_START) && (h_next <= HS_END)) ? HS_ACT : ~HS_ACT;
        vsync   <= ((v_next >= VS_START) && (v_next <= VS_END)) ? VS_ACT : ~VS_ACT;
        hblank  <= (h_next >= H_BLANK);
        vblank  <= (v_next >= V_BLANK);
        de      <= (h_next < H_BLANK) && (v_next < V_BLANK);
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small config A instance plus a default-parameter
// instance for 640x480 line timing.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nRESET, enable, irq_ack_n;
  logic       ce_pix, hsync, vsync, hblank, vblank, de, line_start, frame_start, irq_n;
  logic [9:0] hcount, vcount;

  video_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .IRQ_LINE(3), .HW(10), .VW(10)
  ) dut (
    .clk(clk), .nRESET(nRESET), .enable(enable), .irq_ack_n(irq_ack_n),
    .ce_pix(ce_pix), .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .hblank(hblank), .vblank(vblank), .de(de), .line_start(line_start),
    .frame_start(frame_start), .irq_n(irq_n)
  );

  logic       nreset_d;
  logic       ce_pix_d, hsync_d, vsync_d, hblank_d, vblank_d, de_d, line_start_d, frame_start_d, irq_n_d;
  logic [9:0] hcount_d, vcount_d;

  video_timing_gen dut_d (
    .clk(clk), .nRESET(nreset_d), .enable(1'b1), .irq_ack_n(1'b1),
    .ce_pix(ce_pix_d), .hcount(hcount_d), .vcount(vcount_d), .hsync(hsync_d), .vsync(vsync_d),
    .hblank(hblank_d), .vblank(vblank_d), .de(de_d), .line_start(line_start_d),
    .frame_start(frame_start_d), .irq_n(irq_n_d)
  );

  typedef struct {
    int k;
    int h;
    int v;
    int hs, vs, hb, vb, de, irq;
  } vec_t;

  vec_t tbl[14];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   k;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  function automatic int mh(input int kk);
    return (kk / 3) % 8;
  endfunction

  function automatic int mv(input int kk);
    return (kk / 24) % 6;
  endfunction

  task automatic chk_pos(input string tag);
    int h, v, hb, vb;
    h  = mh(k);
    v  = mv(k);
    hb = (h >= 4) ? 1 : 0;
    vb = (v >= 3) ? 1 : 0;
    chk({tag, " hcount"}, int'(hcount), h);
    chk({tag, " vcount"}, int'(vcount), v);
    chk({tag, " hsync"},  int'(hsync), (h == 5 || h == 6) ? 0 : 1);
    chk({tag, " vsync"},  int'(vsync), (v == 4) ? 0 : 1);
    chk({tag, " hblank"}, int'(hblank), hb);
    chk({tag, " vblank"}, int'(vblank), vb);
    chk({tag, " de"},     int'(de), (hb == 0 && vb == 0) ? 1 : 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " hcount"},      int'(hcount), 0);
    chk({tag, " vcount"},      int'(vcount), 0);
    chk({tag, " hsync"},       int'(hsync), 1);
    chk({tag, " vsync"},       int'(vsync), 1);
    chk({tag, " hblank"},      int'(hblank), 0);
    chk({tag, " vblank"},      int'(vblank), 0);
    chk({tag, " de"},          int'(de), 1);
    chk({tag, " irq_n"},       int'(irq_n), 1);
    chk({tag, " ce_pix"},      int'(ce_pix), 0);
    chk({tag, " line_start"},  int'(line_start), 0);
    chk({tag, " frame_start"}, int'(frame_start), 0);
  endtask

  task automatic check_stream();
    int ce, ls, fs;
    ce = (enable && (k % 3 == 2)) ? 1 : 0;
    ls = (ce == 1 && mh(k) == 7) ? 1 : 0;
    fs = (ls == 1 && mv(k) == 5) ? 1 : 0;
    chk("ce_pix", int'(ce_pix), ce);
    chk("line_start", int'(line_start), ls);
    chk("frame_start", int'(frame_start), fs);
  endtask

  task automatic advance();
    @(posedge clk);
    if (enable) k++;
    @(negedge clk);
    check_stream();
  endtask

  initial begin
    nreset_d = 1'b0;
    #23 nreset_d = 1'b1;
  end

  initial begin
    int idx, k1, cyc, ones;
    bit found;

    //         k    h  v  hs vs hb vb de irq
    tbl[0]  = '{0,   0, 0, 1, 1, 0, 0, 1, 1};
    tbl[1]  = '{3,   1, 0, 1, 1, 0, 0, 1, 1};
    tbl[2]  = '{12,  4, 0, 1, 1, 1, 0, 0, 1};
    tbl[3]  = '{15,  5, 0, 0, 1, 1, 0, 0, 1};
    tbl[4]  = '{18,  6, 0, 0, 1, 1, 0, 0, 1};
    tbl[5]  = '{21,  7, 0, 1, 1, 1, 0, 0, 1};
    tbl[6]  = '{24,  0, 1, 1, 1, 0, 0, 1, 1};
    tbl[7]  = '{71,  7, 2, 1, 1, 1, 0, 0, 1};
    tbl[8]  = '{72,  0, 3, 1, 1, 0, 1, 0, 0};
    tbl[9]  = '{96,  0, 4, 1, 0, 0, 1, 0, 0};
    tbl[10] = '{120, 0, 5, 1, 1, 0, 1, 0, 0};
    tbl[11] = '{126, 2, 5, 1, 1, 0, 1, 0, 0};
    tbl[12] = '{143, 7, 5, 1, 1, 1, 1, 0, 0};
    tbl[13] = '{144, 0, 0, 1, 1, 0, 0, 1, 0};

    nRESET    = 1'b0;
    enable    = 1'b1;
    irq_ack_n = 1'b1;
    k         = 0;
    repeat (4) @(negedge clk);
    chk_reset("reset");
    nRESET = 1'b1;
    check_stream();

    idx = 0;
    for (int step = 0; step < 200 && idx < 14; step++) begin
      if (k == tbl[idx].k) begin
        chk("tbl hcount", int'(hcount), tbl[idx].h);
        chk("tbl vcount", int'(vcount), tbl[idx].v);
        chk("tbl hsync",  int'(hsync),  tbl[idx].hs);
        chk("tbl vsync",  int'(vsync),  tbl[idx].vs);
        chk("tbl hblank", int'(hblank), tbl[idx].hb);
        chk("tbl vblank", int'(vblank), tbl[idx].vb);
        chk("tbl de",     int'(de),     tbl[idx].de);
        chk("tbl irq_n",  int'(irq_n),  tbl[idx].irq);
        idx++;
      end
      if (idx < 14) advance();
    end
    chk("table rows reached", idx, 14);

    // one-cycle acknowledge clears the pending interrupt
    irq_ack_n = 1'b0;
    advance();
    chk("irq cleared by ack", int'(irq_n), 1);
    irq_ack_n = 1'b1;

    // ack held low across the set edge wins
    while (k < 210) advance();
    irq_ack_n = 1'b0;
    while (k < 216) advance();
    chk("irq ack dominates", int'(irq_n), 1);
    while (k < 220) advance();
    irq_ack_n = 1'b1;
    while (k < 359) advance();
    chk("irq before set", int'(irq_n), 1);
    advance();
    chk("irq set frame3", int'(irq_n), 0);

    // freeze mid-line
    while (k < 364) advance();
    chk_pos("pre-freeze");
    enable = 1'b0;
    repeat (10) begin
      advance();
      chk_pos("frozen");
    end
    enable = 1'b1;
    repeat (20) advance();
    chk_pos("resumed");

    // asynchronous reset mid-frame
    #2 nRESET = 1'b0;
    #1 chk_reset("async reset");
    @(negedge clk);
    chk_reset("reset held");
    nRESET = 1'b1;
    k = 0;
    advance();
    advance();
    chk("post-reset hcount before ce", int'(hcount), 0);
    advance();
    chk("post-reset hcount after ce", int'(hcount), 1);

    // frame_start period
    found = 0;
    k1    = 0;
    for (int i = 0; i < 300; i++) begin
      advance();
      if (frame_start) begin
        found = 1;
        k1    = k;
        break;
      end
    end
    chk("frame_start seen", int'(found), 1);
    found = 0;
    cyc   = 0;
    for (int i = 0; i < 300; i++) begin
      advance();
      cyc++;
      if (frame_start) begin
        found = 1;
        break;
      end
    end
    chk("frame_start period", found ? cyc : -1, 144);
    chk("frame_start k", found ? k - k1 : -1, 144);

    // default 640x480 instance
    found = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (line_start_d) begin
        found = 1;
        break;
      end
    end
    chk("dflt line_start seen", int'(found), 1);
    found = 0;
    cyc   = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      cyc++;
      if (line_start_d) begin
        found = 1;
        break;
      end
    end
    chk("dflt line period", found ? cyc : -1, 1600);
    found = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!hsync_d) begin
        found = 1;
        break;
      end
    end
    chk("dflt hsync start hcount", found ? int'(hcount_d) : -1, 656);
    cyc = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (hsync_d) break;
      cyc++;
    end
    chk("dflt hsync low clks", cyc, 192);
    chk("dflt hsync end hcount", int'(hcount_d), 752);
    chk("dflt hblank at hsync end", int'(hblank_d), 1);
    chk("dflt de vs hblank", int'(de_d), 0);
    chk("dflt vsync idle", int'(vsync_d), 1);
    chk("dflt vblank idle", int'(vblank_d), 0);
    chk("dflt irq idle", int'(irq_n_d), 1);
    chk("dflt frame_start idle", int'(frame_start_d), 0);
    ones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ce_pix_d) ones++;
    end
    chk("dflt ce_pix density", ones, 5);
    chk("dflt vcount in frame", (int'(vcount_d) < 480) ? 1 : 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- CLK_DIV, 2, clk cycles per pixel (>=1)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, hsync width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vsync width, in lines
- V_BP, 33, vertical back porch, in lines
- HS_POL, 0, active level of hsync
- VS_POL, 0, active level of vsync
- IRQ_LINE, 480, vcount value that raises the interrupt
- HW, 10, width of hcount
- VW, 10, width of vcount
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on its rising edge
- nRESET, in, 1, asynchronous active-low reset
- enable, in, 1, run/freeze control
- irq_ack_n, in, 1, active-low interrupt acknowledge
- ce_pix, out, 1, pixel clock enable
- hcount, out, HW, horizontal position
- vcount, out, VW, vertical position
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- hblank, out, 1, horizontal blanking
- vblank, out, 1, vertical blanking
- de, out, 1, display enable
- line_start, out, 1, end-of-line pulse
- frame_start, out, 1, end-of-frame pulse
- irq_n, out, 1, active-low interrupt
REQ-003 SHALL define H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; H_TOTAL-1 SHALL fit in HW bits and V_TOTAL-1 in VW bits (elaboration-time check).

Function
REQ-004 Divider: counts 0..CLK_DIV-1, wraps to 0; ce_pix=1 for exactly the clk cycle with divider==CLK_DIV-1; CLK_DIV=1 -> ce_pix constantly 1 while enable=1.
REQ-005 hcount increments on each ce_pix; at H_TOTAL-1 it wraps to 0.
REQ-006 vcount increments only on a ce_pix where hcount wraps; at V_TOTAL-1 it wraps to 0 on that same edge.
REQ-007 enable=0: divider, counters, all registered outputs hold; ce_pix, line_start, frame_start forced 0; resume from held state when enable=1.
REQ-008 hsync = HS_POL when H_ACTIVE+H_FP <= hcount <= H_ACTIVE+H_FP+H_SYNC-1, else ~HS_POL.
REQ-009 vsync = VS_POL when V_ACTIVE+V_FP <= vcount <= V_ACTIVE+V_FP+V_SYNC-1, else ~VS_POL.
REQ-010 hblank=(hcount>=H_ACTIVE); vblank=(vcount>=V_ACTIVE); de=~hblank & ~vblank.
REQ-011 hsync/vsync/hblank/vblank/de SHALL be registers loaded from next-state counter values, so they are always consistent with hcount/vcount in the same cycle (zero skew, no combinational path from counters).
REQ-012 line_start=1 for the single clk cycle with ce_pix=1, enable=1 and hcount==H_TOTAL-1.
REQ-013 frame_start=line_start & (vcount==V_TOTAL-1).
REQ-014 IRQ set event = ce_pix & (hcount==H_TOTAL-1) & (next vcount==IRQ_LINE); irq_n goes 0 on that edge.
REQ-015 irq_n stays 0 until a clk edge samples irq_ack_n=0, then returns to 1.
REQ-016 If set event and irq_ack_n=0 coincide, irq_n SHALL be 1 (ack dominates).
REQ-017 irq_n already 0 at a new set event: stays 0, no queuing.
REQ-018 IRQ_LINE>=V_TOTAL: irq_n never asserts.

Reset
REQ-019 nRESET=0 asynchronously forces: divider=0, hcount=0, vcount=0, hsync=~HS_POL, vsync=~VS_POL, hblank=0, vblank=0, de=1, irq_n=1, line_start=frame_start=ce_pix=0.
REQ-020 Reset asserted mid-line/mid-frame abandons position; after release, the first ce_pix occurs CLK_DIV clk cycles later and advances hcount 0->1.

Verification
Bench config A (small): CLK_DIV=3, H=4/1/2/1 (H_TOTAL=8), V=3/1/1/1 (V_TOTAL=6), HS_POL=VS_POL=0, IRQ_LINE=3.
REQ-021 Config A, reset release, enable=1 -> ce_pix every 3rd clk; hcount 0..7 wraps; vcount 0..5 wraps; frame_start period 144 clk.
REQ-022 Config A -> hsync=0 exactly at hcount 5,6; hblank=1 at hcount 4..7; vsync=0 exactly at vcount 4; de=1 only for hcount<4 and vcount<3.
REQ-023 Config A, irq_ack_n=1 -> irq_n falls on the edge vcount becomes 3; pulsing irq_ack_n=0 for 1 clk -> irq_n=1 next edge; ack held low across the set edge -> irq_n stays 1.
REQ-024 Config A, enable=0 for 10 clk mid-line -> counters/outputs frozen, no ce_pix or line_start; resume continues from frozen values.
REQ-025 Defaults (640x480, CLK_DIV=2) -> 1600 clk per line, 525 lines, hsync low 96 pixels starting at hcount 656, vsync low at vcount 490,491.
REQ-026 nRESET pulsed low mid-frame -> all outputs take REQ-019 values immediately, without waiting for a clk edge.
